// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - opcode constants, predecode entry layout and predecode function
package esm_pkg;

    // RV32I major opcodes recognised by the predecoder
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Predecode bits stored beside each instruction; a queue entry is
    // {instr, predec_t}, so these three bits occupy the entry LSBs.
    typedef struct packed {
        logic reg_write;
        logic alu_src;
        logic illegal;
    } predec_t;

    localparam int PD_W = $bits(predec_t);

    function automatic predec_t predecode(input logic [6:0] opcode);
        predec_t pd;
        pd = '{reg_write: 1'b0, alu_src: 1'b0, illegal: 1'b0};
        case (opcode)
            OP_REG:                               pd.reg_write = 1'b1;
            OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC: begin
                pd.reg_write = 1'b1;
                pd.alu_src   = 1'b1;
            end
            OP_STORE:                             pd.alu_src   = 1'b1;
            OP_BRANCH:                            ;
            OP_JAL, OP_JALR:                      pd.reg_write = 1'b1;
            default:                              pd.illegal   = 1'b1;
        endcase
        return pd;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO holding predecoded instruction entries
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   flush         drop all contents (pointers and count to zero)
//   push, wdata   write one entry; caller guarantees not full
//   pop           retire head; caller guarantees not empty
//   rdata         current head entry (combinational read)
//   count         occupancy, 0..DEPTH
module instr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/predecode_queue.sv
// rtl/predecode_queue.sv - instruction queue with push-time predecode feeding the ESM
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_instr/in_valid        fetched instruction, accepted when in_ready=1
//   in_ready                 queue not full and out of reset
//   stall                    freeze output stage, no pop (pushes continue)
//   flush                    discard queue and output stage
//   Instr_out, RegWrite,
//   ALUSrc, illegal,
//   out_valid                registered output stage
//   count                    queue occupancy
module predecode_queue
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Instruction_word_size-1:0] in_instr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             stall,
    input  logic                             flush,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             RegWrite,
    output logic                             ALUSrc,
    output logic                             out_valid,
    output logic                             illegal,
    output logic [$clog2(bs+1)-1:0]          count
);

    localparam int W  = Instruction_word_size;
    localparam int EW = W + PD_W;
    localparam int CW = $clog2(bs + 1);

    logic [EW-1:0] wr_entry, head_entry;
    logic [CW-1:0] fifo_count;
    logic          push, pop;
    predec_t       head_pd;

    logic [W-1:0]  instr_q, instr_d;
    predec_t       pd_q, pd_d;
    logic          valid_q, valid_d;
    // Held low through reset so in_ready rises only on the first edge after release.
    logic          ready_q;

    assign in_ready = ready_q && (fifo_count < CW'(bs));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !stall && (fifo_count != '0) && !flush;
    assign wr_entry = {in_instr, predecode(in_instr[6:0])};

    instr_fifo #(
        .DEPTH (bs),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head_entry),
        .count (fifo_count)
    );

    assign head_pd = predec_t'(head_entry[PD_W-1:0]);

    // Unstalled with an empty queue the output stage loads a bubble.
    always_comb begin
        instr_d = instr_q;
        pd_d    = pd_q;
        valid_d = valid_q;
        if (!stall) begin
            if (pop) begin
                instr_d = head_entry[EW-1:PD_W];
                pd_d    = head_pd;
                valid_d = 1'b1;
            end else begin
                instr_d = '0;
                pd_d    = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= '0;
            pd_q    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else if (flush) begin
            instr_q <= '0;
            pd_q    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            instr_q <= instr_d;
            pd_q    <= pd_d;
            valid_q <= valid_d;
            ready_q <= 1'b1;
        end
    end

    assign Instr_out = instr_q;
    assign RegWrite  = pd_q.reg_write;
    assign ALUSrc    = pd_q.alu_src;
    assign illegal   = pd_q.illegal;
    assign out_valid = valid_q;
    assign count     = fifo_count;

endmodule

// File: tb/tb_predecode_queue.sv
// tb/tb_predecode_queue.sv - self-checking scoreboard bench for predecode_queue
module tb_predecode_queue;

    localparam int W  = 32;
    localparam int BS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_instr;
    logic          in_valid;
    logic          in_ready;
    logic          stall;
    logic          flush;
    logic [W-1:0]  Instr_out;
    logic          RegWrite;
    logic          ALUSrc;
    logic          out_valid;
    logic          illegal;
    logic [4:0]    count;

    always #5 clk = ~clk;

    predecode_queue #(
        .Instruction_word_size (W),
        .bs                    (BS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_instr  (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .Instr_out (Instr_out),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .out_valid (out_valid),
        .illegal   (illegal),
        .count     (count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected entry: {instr, reg_write, alu_src, illegal}
    function automatic logic [W+2:0] mk_entry(input logic [W-1:0] instr);
        logic [2:0] pd;
        case (instr[6:0])
            7'h33:                      pd = 3'b100;
            7'h13, 7'h03, 7'h37, 7'h17: pd = 3'b110;
            7'h23:                      pd = 3'b010;
            7'h63:                      pd = 3'b000;
            7'h6f, 7'h67:               pd = 3'b100;
            default:                    pd = 3'b001;
        endcase
        return {instr, pd};
    endfunction

    logic [W+2:0] sb[$];
    logic [W+3:0] m_out;     // {valid, instr, rw, as, ill}
    logic         m_rdy;
    int           pushed;

    task automatic step();
        logic exp_rdy, do_push, do_pop;
        exp_rdy = m_rdy && (sb.size() < BS);
        check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
        do_push = rst && !flush && in_valid && exp_rdy;
        do_pop  = rst && !flush && !stall && (sb.size() > 0);
        @(posedge clk);
        #1;
        if (!rst) begin
            sb.delete();
            m_out = '0;
            m_rdy = 1'b0;
        end else if (flush) begin
            sb.delete();
            m_out = '0;
            m_rdy = 1'b1;
        end else begin
            m_rdy = 1'b1;
            if (!stall) begin
                if (do_pop) m_out = {1'b1, sb.pop_front()};
                else        m_out = '0;
            end
            if (do_push) begin
                sb.push_back(mk_entry(in_instr));
                pushed++;
            end
        end
        check("Instr_out", {32'b0, Instr_out}, {32'b0, m_out[W+2:3]});
        check("RegWrite",  {63'b0, RegWrite},  {63'b0, m_out[2]});
        check("ALUSrc",    {63'b0, ALUSrc},    {63'b0, m_out[1]});
        check("illegal",   {63'b0, illegal},   {63'b0, m_out[0]});
        check("out_valid", {63'b0, out_valid}, {63'b0, m_out[W+3]});
        check("count",     {59'b0, count},     64'(sb.size()));
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] ins);
        in_valid = v;
        in_instr = ins;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    function automatic logic [W-1:0] rand_instr();
        logic [6:0] ops [10];
        logic [W-1:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h7f};
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        m_out    = '0;
        m_rdy    = 1'b0;
        pushed   = 0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        // Reset held: outputs zero, in_ready low
        step();
        rst = 1'b1;
        idle(2);

        // Single ADDI into empty queue
        drive(1'b1, 32'h00A00093);
        idle(3);

        // ADD then all-zero (illegal)
        drive(1'b1, 32'h002081B3);
        drive(1'b1, 32'h00000000);
        idle(3);

        // Fill under stall; extra words refused while full
        stall = 1'b1;
        for (int i = 0; i < 18; i++) drive(1'b1, 32'h1000_0013 + (i << 12));
        in_valid = 1'b0;
        stall = 1'b0;
        idle(BS + 3);

        // 40 words with random in_valid, stall low
        pushed = 0;
        for (int i = 0; i < 600 && pushed < 40; i++) begin
            drive(1'($urandom_range(0, 1)), rand_instr());
        end
        check("burst_pushed", 64'(pushed), 64'd40);
        idle(BS + 3);

        // Flush with five queued words and a word offered
        stall = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, rand_instr());
        flush = 1'b1;
        drive(1'b1, 32'hDEAD_0033);
        flush = 1'b0;
        stall = 1'b0;
        idle(3);

        // One-edge reset with seven queued words, then resume
        stall = 1'b1;
        for (int i = 0; i < 7; i++) drive(1'b1, rand_instr());
        stall = 1'b0;
        rst = 1'b0;
        drive(1'b1, 32'h0000_0033);
        rst = 1'b1;
        drive(1'b1, 32'h0000_0013);
        for (int i = 0; i < 4; i++) drive(1'b1, rand_instr());
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/predecode_queue.md
PREDECODE_QUEUE -- requirements
Module: predecode_queue

Interface
REQ-001 SHALL have parameter Instruction_word_size, default 32, instruction width in bits.
REQ-002 SHALL have parameter bs, default 16, queue depth in entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low (0 = reset).
REQ-005 SHALL have port in_instr  input  Instruction_word_size  fetched instruction.
REQ-006 SHALL have port in_valid  input  1  in_instr valid this cycle.
REQ-007 SHALL have port in_ready  output  1  queue accepts in_instr this cycle.
REQ-008 SHALL have port stall  input  1  downstream ESM hold; freezes output stage.
REQ-009 SHALL have port flush  input  1  discard all queued and output-stage contents.
REQ-010 SHALL have port Instr_out  output  Instruction_word_size  instruction to ESM Instr_in.
REQ-011 SHALL have port RegWrite  output  1  predecoded write-enable for Instr_out.
REQ-012 SHALL have port ALUSrc  output  1  predecoded immediate-operand select for Instr_out.
REQ-013 SHALL have port out_valid  output  1  Instr_out holds a real instruction.
REQ-014 SHALL have port illegal  output  1  Instr_out opcode not in predecode table.
REQ-015 SHALL have port count  output  $clog2(bs+1)  current queue occupancy.

Function
REQ-016 SHALL accept (push) in_instr on an edge where in_valid=1, in_ready=1, flush=0.
REQ-017 SHALL drive in_ready = (count < bs); no push-through when full, even with simultaneous pop.
REQ-018 SHALL predecode at push time, storing {instr, RegWrite, ALUSrc, illegal} per entry.
REQ-019 SHALL predecode opcode [6:0]: 0110011 -> RW=1,AS=0; 0010011, 0000011, 0110111, 0010111 -> RW=1,AS=1; 0100011 -> RW=0,AS=1; 1100011 -> RW=0,AS=0; 1101111, 1100111 -> RW=1,AS=0.
REQ-020 SHALL mark any other opcode illegal=1 with RW=0,AS=0; all-zero word is illegal.
REQ-021 SHALL, when stall=0 and count>0, pop head into output registers with out_valid=1.
REQ-022 SHALL, when stall=0 and count=0, load output registers with zero (Instr_out=0, RegWrite=0, ALUSrc=0, illegal=0, out_valid=0).
REQ-023 SHALL hold all output registers and perform no pop while stall=1; pushes continue.
REQ-024 SHALL give 2-cycle latency: word pushed at edge N into empty queue appears on Instr_out after edge N+1 (stall=0).
REQ-025 SHALL update count by +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-026 SHALL wrap read/write pointers modulo bs without loss or duplication.
REQ-027 SHALL on flush=1 clear count, pointers and output registers to reset values next edge, ignoring same-cycle push/pop.
REQ-028 SHALL preserve program order; no reordering, no dropped accepted words.

Reset
REQ-029 SHALL, while rst=0 at an edge, set count=0, pointers=0, Instr_out=0, RegWrite=0, ALUSrc=0, illegal=0, out_valid=0.
REQ-030 SHALL drive in_ready=0 during reset cycle effect and 1 from first edge after rst returns to 1.
REQ-031 SHALL discard partially-queued contents on reset asserted mid-operation; storage array needs no reset.

Structure
REQ-032 SHALL place opcode constants and predecode entry field layout in shared package esm_pkg.
REQ-033 SHALL instantiate one sub-module instr_fifo (sync FIFO, depth bs, width Instruction_word_size+3).
REQ-034 SHALL implement predecode as a combinational function in esm_pkg, not a sub-module.

Verification
REQ-035 SHALL cover: push 0x00A00093 into empty queue -> 2 edges later Instr_out=0x00A00093, RegWrite=1, ALUSrc=1, out_valid=1.
REQ-036 SHALL cover: push 0x002081B3 then 0x00000000 -> first RW=1,AS=0,illegal=0; second out_valid=1, illegal=1, RW=0.
REQ-037 SHALL cover: stall=1, push 16 words -> count=16, in_ready=0; 17th word not accepted; release stall -> 16 words out in order.
REQ-038 SHALL cover: push 40 words at stall=0 with random in_valid -> pointer wrap, order preserved, count never >16.
REQ-039 SHALL cover: flush with count=5 and in_valid=1 -> next edge count=0, out_valid=0, flushed word not queued.
REQ-040 SHALL cover: rst=0 for one edge mid-stream with count=7 -> all outputs zero, count=0; resumes cleanly.
